// File: rtl/unidad_procesadora.sv
// Datapath of the microprogrammed CPU: 8x4 register file, ALU/shifter and B/D muxes.
// Optional macro FLAGS_REG_EN registers the status flags instead of driving them combinationally.
module unidad_procesadora (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] control,
    input  logic [3:0]  datain,
    input  logic [3:0]  Constant_IN,
    output logic [3:0]  flags,
    output logic [3:0]  dataout,
    output logic [3:0]  adr_out
);

    logic [2:0] da, aa, ba;
    logic       mb, md, rw;
    logic [3:0] fs;

    assign da = control[15:13];
    assign aa = control[12:10];
    assign ba = control[9:7];
    assign mb = control[6];
    assign fs = control[5:2];
    assign md = control[1];
    assign rw = control[0];

    logic [3:0] regs [8];
    logic [3:0] bus_a, bus_b, bus_d, f;
    logic       v_flag, c_flag;

    assign bus_a   = regs[aa];
    assign bus_b   = mb ? Constant_IN : regs[ba];
    assign bus_d   = md ? datain : f;
    assign adr_out = bus_a;
    assign dataout = bus_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 4'b0000;
            end
        end else if (rw) begin
            regs[da] <= bus_d;
        end
    end

    // Arithmetic group shares one adder: FS[2:0] selects the second operand and carry-in.
    logic [3:0] op_b;
    logic       cin;
    logic [4:0] sum;

    always_comb begin
        op_b = 4'b0000;
        cin  = 1'b0;
        case (fs[2:0])
            3'b000: begin op_b = 4'b0000; cin = 1'b0; end
            3'b001: begin op_b = 4'b0000; cin = 1'b1; end
            3'b010: begin op_b = bus_b;   cin = 1'b0; end
            3'b011: begin op_b = bus_b;   cin = 1'b1; end
            3'b100: begin op_b = ~bus_b;  cin = 1'b0; end
            3'b101: begin op_b = ~bus_b;  cin = 1'b1; end
            3'b110: begin op_b = 4'b1111; cin = 1'b0; end
            default: begin op_b = 4'b0000; cin = 1'b0; end
        endcase
        sum = {1'b0, bus_a} + {1'b0, op_b} + {4'b0000, cin};
    end

    always_comb begin
        f      = 4'b0000;
        c_flag = 1'b0;
        v_flag = 1'b0;
        if (fs[3] == 1'b0) begin
            f      = sum[3:0];
            c_flag = sum[4];
            v_flag = (bus_a[3] == op_b[3]) && (sum[3] != bus_a[3]);
        end else begin
            case (fs[2:0])
                3'b000: f = bus_a & bus_b;
                3'b001: f = bus_a | bus_b;
                3'b010: f = bus_a ^ bus_b;
                3'b011: f = ~bus_a;
                3'b100: f = bus_b;
                3'b101: begin f = {1'b0, bus_b[3:1]}; c_flag = bus_b[0]; end
                3'b110: begin f = {bus_b[2:0], 1'b0}; c_flag = bus_b[3]; end
                default: f = 4'b0000;
            endcase
        end
    end

    logic [3:0] flags_comb;
    assign flags_comb = {v_flag, c_flag, f[3], (f == 4'b0000)};

`ifdef FLAGS_REG_EN
    logic [3:0] flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_comb;
        end
    end

    assign flags = flags_q;
`else
    assign flags = flags_comb;
`endif

endmodule

// File: tb/tb_unidad_procesadora.sv
// Directed self-checking bench for unidad_procesadora; follows FLAGS_REG_EN if defined.
module tb_unidad_procesadora;

    logic        clk;
    logic        rst_n;
    logic [15:0] control;
    logic [3:0]  datain;
    logic [3:0]  Constant_IN;
    logic [3:0]  flags;
    logic [3:0]  dataout;
    logic [3:0]  adr_out;

    int checks = 0;
    int errors = 0;

    unidad_procesadora dut (
        .clk(clk),
        .rst_n(rst_n),
        .control(control),
        .datain(datain),
        .Constant_IN(Constant_IN),
        .flags(flags),
        .dataout(dataout),
        .adr_out(adr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] cw(input logic [2:0] da, input logic [2:0] aa,
                                       input logic [2:0] ba, input logic mb,
                                       input logic [3:0] fs, input logic md, input logic rw);
        return {da, aa, ba, mb, fs, md, rw};
    endfunction

    task automatic do_write(input logic [15:0] w);
        control = w;
        @(posedge clk);
        #1;
        control = cw(3'd0, 3'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
        #1;
    endtask

    task automatic load_reg(input logic [2:0] idx, input logic [3:0] val);
        datain = val;
        do_write(cw(idx, 3'd0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b1));
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [3:0] val);
        control = cw(3'd0, idx, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
        #1;
        val = adr_out;
    endtask

    // Control word must already be applied with RW=0; registered flags need one edge.
    task automatic sample_flags(output logic [3:0] val);
`ifdef FLAGS_REG_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
        val = flags;
    endtask

    task automatic test_reset;
        logic [3:0] exp_flags;
        rst_n = 1'b0;
        datain = 4'b0000;
        Constant_IN = 4'b1010;
        control = cw(3'd0, 3'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
        #3;
        checks++;
        if (adr_out !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_adr_out got %b expected %b", adr_out, 4'b0000);
        end
        checks++;
        if (dataout !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_dataout_mb0 got %b expected %b", dataout, 4'b0000);
        end
        control = cw(3'd0, 3'd0, 3'd0, 1'b1, 4'b0000, 1'b0, 1'b0);
        #1;
        checks++;
        if (dataout !== 4'b1010) begin
            errors++; $display("[TB] FAIL reset_dataout_mb1 got %b expected %b", dataout, 4'b1010);
        end
`ifdef FLAGS_REG_EN
        exp_flags = 4'b0000;
`else
        exp_flags = 4'b0001;
`endif
        checks++;
        if (flags !== exp_flags) begin
            errors++; $display("[TB] FAIL reset_flags got %b expected %b", flags, exp_flags);
        end
        control = cw(3'd0, 3'd0, 3'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (flags !== 4'b0001) begin
            errors++; $display("[TB] FAIL post_reset_flags got %b expected %b", flags, 4'b0001);
        end
    endtask

    task automatic test_load;
        logic [3:0] v, fl;
        load_reg(3'd1, 4'b0101);
        read_reg(3'd1, v);
        checks++;
        if (v !== 4'b0101) begin
            errors++; $display("[TB] FAIL load_r1 got %b expected %b", v, 4'b0101);
        end
        sample_flags(fl);
        checks++;
        if (fl !== 4'b0000) begin
            errors++; $display("[TB] FAIL load_flags got %b expected %b", fl, 4'b0000);
        end
        datain = 4'b1111;
        do_write(cw(3'd1, 3'd0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b0));
        read_reg(3'd1, v);
        checks++;
        if (v !== 4'b0101) begin
            errors++; $display("[TB] FAIL rw0_no_write got %b expected %b", v, 4'b0101);
        end
    endtask

    task automatic test_add;
        logic [3:0] v, fl;
        load_reg(3'd2, 4'b0011);
        control = cw(3'd3, 3'd1, 3'd2, 1'b0, 4'b0010, 1'b0, 1'b0);
        sample_flags(fl);
        checks++;
        if (fl !== 4'b1010) begin
            errors++; $display("[TB] FAIL add_flags got %b expected %b", fl, 4'b1010);
        end
        do_write(cw(3'd3, 3'd1, 3'd2, 1'b0, 4'b0010, 1'b0, 1'b1));
        read_reg(3'd3, v);
        checks++;
        if (v !== 4'b1000) begin
            errors++; $display("[TB] FAIL add_r3 got %b expected %b", v, 4'b1000);
        end
        // R1 <= R1+1: old value visible before the edge, new one after
        control = cw(3'd1, 3'd1, 3'd0, 1'b0, 4'b0001, 1'b0, 1'b1);
        #1;
        checks++;
        if (adr_out !== 4'b0101) begin
            errors++; $display("[TB] FAIL inc_no_bypass got %b expected %b", adr_out, 4'b0101);
        end
        do_write(cw(3'd1, 3'd1, 3'd0, 1'b0, 4'b0001, 1'b0, 1'b1));
        read_reg(3'd1, v);
        checks++;
        if (v !== 4'b0110) begin
            errors++; $display("[TB] FAIL inc_r1 got %b expected %b", v, 4'b0110);
        end
        load_reg(3'd2, 4'b0111);
        control = cw(3'd0, 3'd2, 3'd0, 1'b0, 4'b0001, 1'b0, 1'b0);
        sample_flags(fl);
        checks++;
        if (fl !== 4'b1010) begin
            errors++; $display("[TB] FAIL inc_overflow_flags got %b expected %b", fl, 4'b1010);
        end
    endtask

    task automatic test_subtract;
        logic [3:0] v, fl;
        load_reg(3'd1, 4'b0101);
        load_reg(3'd2, 4'b0011);
        control = cw(3'd0, 3'd2, 3'd1, 1'b0, 4'b0101, 1'b0, 1'b0);
        #1;
        checks++;
        if (dataout !== 4'b0101) begin
            errors++; $display("[TB] FAIL sub_dataout got %b expected %b", dataout, 4'b0101);
        end
        sample_flags(fl);
        checks++;
        if (fl !== 4'b0010) begin
            errors++; $display("[TB] FAIL sub_flags got %b expected %b", fl, 4'b0010);
        end
        do_write(cw(3'd4, 3'd2, 3'd1, 1'b0, 4'b0101, 1'b0, 1'b1));
        read_reg(3'd4, v);
        checks++;
        if (v !== 4'b1110) begin
            errors++; $display("[TB] FAIL sub_result got %b expected %b", v, 4'b1110);
        end
        control = cw(3'd0, 3'd1, 3'd1, 1'b0, 4'b0101, 1'b0, 1'b0);
        sample_flags(fl);
        checks++;
        if (fl !== 4'b0101) begin
            errors++; $display("[TB] FAIL sub_equal_flags got %b expected %b", fl, 4'b0101);
        end
        control = cw(3'd0, 3'd0, 3'd0, 1'b0, 4'b0110, 1'b0, 1'b0);
        sample_flags(fl);
        checks++;
        if (fl !== 4'b0010) begin
            errors++; $display("[TB] FAIL dec_zero_flags got %b expected %b", fl, 4'b0010);
        end
    endtask

    task automatic test_constant_shift;
        logic [3:0] v, fl;
        Constant_IN = 4'b1001;
        control = cw(3'd0, 3'd0, 3'd0, 1'b1, 4'b1110, 1'b0, 1'b0);
        #1;
        checks++;
        if (dataout !== 4'b1001) begin
            errors++; $display("[TB] FAIL const_dataout got %b expected %b", dataout, 4'b1001);
        end
        sample_flags(fl);
        checks++;
        if (fl !== 4'b0100) begin
            errors++; $display("[TB] FAIL shl_flags got %b expected %b", fl, 4'b0100);
        end
        do_write(cw(3'd4, 3'd0, 3'd0, 1'b1, 4'b1110, 1'b0, 1'b1));
        read_reg(3'd4, v);
        checks++;
        if (v !== 4'b0010) begin
            errors++; $display("[TB] FAIL shl_result got %b expected %b", v, 4'b0010);
        end
        control = cw(3'd0, 3'd0, 3'd0, 1'b1, 4'b1101, 1'b0, 1'b0);
        sample_flags(fl);
        checks++;
        if (fl !== 4'b0100) begin
            errors++; $display("[TB] FAIL shr_flags got %b expected %b", fl, 4'b0100);
        end
        do_write(cw(3'd5, 3'd0, 3'd0, 1'b1, 4'b1101, 1'b0, 1'b1));
        read_reg(3'd5, v);
        checks++;
        if (v !== 4'b0100) begin
            errors++; $display("[TB] FAIL shr_result got %b expected %b", v, 4'b0100);
        end
    endtask

    task automatic test_logic;
        logic [3:0] fs_tab   [6] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1111};
        logic [3:0] res_tab  [6] = '{4'b0001, 4'b0111, 4'b0110, 4'b1010, 4'b0011, 4'b0000};
        logic [3:0] flag_tab [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
        logic [3:0] v, fl;
        load_reg(3'd1, 4'b0101);
        load_reg(3'd2, 4'b0011);
        for (int i = 0; i < 6; i++) begin
            control = cw(3'd6, 3'd1, 3'd2, 1'b0, fs_tab[i], 1'b0, 1'b0);
            sample_flags(fl);
            checks++;
            if (fl !== flag_tab[i]) begin
                errors++; $display("[TB] FAIL logic_flags_fs%b got %b expected %b", fs_tab[i], fl, flag_tab[i]);
            end
            do_write(cw(3'd6, 3'd1, 3'd2, 1'b0, fs_tab[i], 1'b0, 1'b1));
            read_reg(3'd6, v);
            checks++;
            if (v !== res_tab[i]) begin
                errors++; $display("[TB] FAIL logic_result_fs%b got %b expected %b", fs_tab[i], v, res_tab[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] v;
        for (int i = 1; i < 8; i++) begin
            load_reg(i[2:0], 4'(i + 8));
        end
        read_reg(3'd7, v);
        checks++;
        if (v !== 4'b1111) begin
            errors++; $display("[TB] FAIL preload_r7 got %b expected %b", v, 4'b1111);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_reg(i[2:0], v);
            checks++;
            if (v !== 4'b0000) begin
                errors++; $display("[TB] FAIL async_clear_r%0d got %b expected %b", i, v, 4'b0000);
            end
        end
        datain = 4'b1111;
        do_write(cw(3'd1, 3'd0, 3'd0, 1'b0, 4'b0000, 1'b1, 1'b1));
        read_reg(3'd1, v);
        checks++;
        if (v !== 4'b0000) begin
            errors++; $display("[TB] FAIL write_in_reset got %b expected %b", v, 4'b0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        load_reg(3'd1, 4'b1100);
        read_reg(3'd1, v);
        checks++;
        if (v !== 4'b1100) begin
            errors++; $display("[TB] FAIL write_after_reset got %b expected %b", v, 4'b1100);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add();
        test_subtract();
        test_constant_shift();
        test_logic();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidad_procesadora.md
# unidad_procesadora

4-bit processing unit (datapath) of the simple microprogrammed CPU: an 8 × 4-bit register file, a function unit (ALU + shifter), and the B-source and D-source multiplexers. A 16-bit control word from the control unit drives it each cycle. It exposes the A bus as a memory address, the B bus as write data, and four status flags back to the control unit.

## Interface
- No parameters (data width 4 and register count 8 are fixed).
- clk  in  1  system clock; all register writes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- control  in  16  control word: [15:13] DA, [12:10] AA, [9:7] BA, [6] MB, [5:2] FS, [1] MD, [0] RW.
- datain  in  4  data from memory, selected onto bus D when MD=1.
- Constant_IN  in  4  immediate, selected onto bus B when MB=1.
- flags  out  4  status {V,C,N,Z}: flags[3]=V, [2]=C, [1]=N, [0]=Z.
- dataout  out  4  bus B, the MB-mux output.
- adr_out  out  4  bus A, equal to R[AA].

## Operation
- Register file: R0..R7, 4 bits each. Two combinational read ports: A=R[AA], B=R[BA]. One write port: R[DA] <= busD on the rising clk edge when RW=1. R0 is an ordinary writable register.
- busB = MB ? Constant_IN : R[BA].
- busD = MD ? datain : F.
- Function unit F (4-bit result, 5-bit internal sum for carry), by FS:
  - 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1.
  - 0100 A+~B; 0101 A+~B+1 (A−B); 0110 A−1 (A+1111); 0111 A.
  - 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A.
  - 1100 B; 1101 B>>1, zero fill; 1110 B<<1, zero fill; 1111 0000.
- Flags:
  - Z = (F==0); N = F[3].
  - Arithmetic FS 0000–0111: C = bit 4 of the sum; V = signed overflow (operands same sign, result sign differs).
  - Shifts: C = shifted-out bit (1101→B[0], 1110→B[3]); V=0.
  - Logic, transfer and 1111: C=0, V=0.
- busB, busD, F, adr_out, dataout and (default) flags are purely combinational functions of control, inputs and register contents.

## Timing
- rst_n low clears R0..R7 to 0 immediately, independent of clk, and holds them while low. Release is synchronous-safe: the first write happens on the first rising edge after rst_n is high.
- After reset, with all registers 0:
  - adr_out = 0.
  - dataout = 0 if MB=0, else Constant_IN.
  - With FS=0000 the default flags are 4'b0001 (Z=1).
- Write latency: one edge. The new value is visible on the read ports after the edge. A same-cycle read of DA returns the old value (no bypass).
- Simultaneous read and write of the same register in one control word, e.g. R1 <= R1+1: well defined, because the read is combinational and the write happens at the edge.
- RW=0: no register changes; the other fields only affect combinational outputs.

## Configuration
- FLAGS_REG_EN defined: flags becomes a 4-bit register loaded every rising edge with the combinational flag values, cleared to 0 by rst_n. Flags then lag F by one cycle.
- FLAGS_REG_EN undefined (default): flags is combinational from the current F.

## Test plan
- Load: control DA=001, MD=1, RW=1, datain=0101, edge → then AA=001, FS=0000 gives adr_out=0101, flags Z=0.
- Add: R1=5, R2=3; DA=011, AA=001, BA=010, FS=0010, RW=1, edge → R3=1000; before the edge flags={V=1,C=0,N=1,Z=0}.
- Subtract: R2=3, R1=5; AA=010, BA=001, FS=0101 → F=1110, C=0, N=1, V=0. With AA=BA=001 → F=0, Z=1, C=1.
- Constant/shift: MB=1, Constant_IN=1001 → dataout=1001. FS=1110 gives F=0010 with C=1; FS=1101 gives F=0100 with C=1.
- Reset mid-operation:
  - Load R1..R7 with nonzero values.
  - Drop rst_n between edges → all reads return 0 immediately.
  - Write attempts while rst_n is low have no effect.
- FLAGS_REG_EN: FS=0000 with A=0 → flags=0001 only after the next edge; it is 0000 during reset.
